adder_operand_driver: RTL and testbench

- Drives operand pairs into the registered 8-bit fixed-point adder (`addertop`) and collects its results.
- Upstream side: accepts Q1.7 two's-complement operand pairs on a valid/ready handshake.
- Adder side: presents the operands on the adder's A/B, waits the adder's fixed latency, then samples O.
- Downstream side: returns each sum with an overflow flag through a small result FIFO, also on valid/ready.
- Position: sits between the board-level operand source (switches or host) and the result sink (LEDs or UART), on the far side of the adder's A/B/O interface.

---
 rtl/q17_pkg.sv | 30 +++
 rtl/res_fifo.sv | 60 ++++++
 rtl/adder_operand_driver.sv | 122 ++++++++++++
 tb/tb_adder_operand_driver.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/q17_pkg.sv
// Shared Q1.7 fixed-point definitions for the adder operand driver: widths,
// format constants, driver FSM states and the result record.
package q17_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int FRAC_BITS = 7;

  localparam logic [DEF_WIDTH-1:0] Q_MAX     = 8'h7F;
  localparam logic [DEF_WIDTH-1:0] Q_MIN     = 8'h80;
  localparam logic [DEF_WIDTH-1:0] Q_QUARTER = 8'h20;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2
  } drv_state_e;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] sum;
    logic                 ovf;
  } res_t;

  // Two's-complement add overflows only when both operands share a sign
  // and the result's sign differs from it.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/res_fifo.sv
// Synchronous result FIFO with registered pointers and occupancy count.
// Storage is not reset; the head output reads as zero while empty.
module res_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          push_en;
  logic          pop_en;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign count   = cnt_q;
  assign dout    = empty ? '0 : mem[rd_q];

  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_q] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_en) begin
        wr_q <= wr_q + 1'b1;
      end
      if (pop_en) begin
        rd_q <= rd_q + 1'b1;
      end
      case ({push_en, pop_en})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/adder_operand_driver.sv
// Feeds Q1.7 operand pairs to a registered adder, waits its latency, and
// queues {sum, overflow} results. Define ADDER_DRV_SAT_EN to saturate sums.
module adder_operand_driver
  import q17_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int ADD_LATENCY = 1,
  parameter int FIFO_DEPTH  = 4,
  localparam int CNT_W      = 3,
  localparam int FC_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy,
  output logic [FC_W-1:0]  fifo_count
);

  drv_state_e              state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic signed [WIDTH-1:0] add_a_q;
  logic signed [WIDTH-1:0] add_b_q;

  logic                    ovf_d;
  logic signed [WIDTH-1:0] sum_d;
  logic                    push;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [WIDTH:0]          fifo_dout;

  // Clamp to the most positive / most negative code on overflow.
  function automatic logic signed [WIDTH-1:0] sat_q17(
    input logic signed [WIDTH-1:0] raw,
    input logic                    ovf,
    input logic                    neg
  );
    if (!ovf) begin
      return raw;
    end
    return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  assign in_ready = (state_q == IDLE) && !fifo_full;
  assign busy     = (state_q != IDLE);
  assign add_a    = add_a_q;
  assign add_b    = add_b_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      add_a_q <= '0;
      add_b_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            add_a_q <= in_a;
            add_b_q <= in_b;
            cnt_q   <= CNT_W'(ADD_LATENCY - 1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= CAPTURE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        CAPTURE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // ---- capture stage: adder output plus flag computed from held operands
  assign ovf_d = signed_ovf(add_a_q[WIDTH-1], add_b_q[WIDTH-1], add_o[WIDTH-1]);

`ifdef ADDER_DRV_SAT_EN
  assign sum_d = sat_q17(add_o, ovf_d, add_a_q[WIDTH-1]);
`else
  assign sum_d = add_o;
`endif

  // FIFO cannot be full here: IDLE only accepts with a free slot.
  assign push = (state_q == CAPTURE);

  res_fifo #(
    .W     (WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk   (CLK),
    .rst_n (RESET),
    .push  (push),
    .din   ({sum_d, ovf_d}),
    .pop   (out_ready),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_sum   = fifo_dout[WIDTH:1];
  assign out_ovf   = fifo_dout[0];

endmodule

// File: tb/tb_adder_operand_driver.sv
// Self-checking bench for adder_operand_driver with a registered adder model
// and a queue-based reference of expected results.
module tb_adder_operand_driver;

  localparam int LAT = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = 8'h00;
  logic [7:0] in_b = 8'h00;
  logic [7:0] add_a;
  logic [7:0] add_b;
  logic [7:0] add_o;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_sum;
  logic       out_ovf;
  logic       busy;
  logic [2:0] fifo_count;

  int errors = 0;
  int checks = 0;

  logic [8:0] exp_q[$];   // {ovf, sum} in acceptance order
  logic [7:0] add_pipe [LAT];

  always #5 clk = ~clk;

  // Registered adder standing in for addertop.
  always @(posedge clk) begin
    add_pipe[0] <= add_a + add_b;
    for (int i = 1; i < LAT; i++) add_pipe[i] <= add_pipe[i-1];
  end
  assign add_o = add_pipe[LAT-1];

  adder_operand_driver #(
    .WIDTH       (8),
    .ADD_LATENCY (LAT),
    .FIFO_DEPTH  (4)
  ) dut (
    .CLK        (clk),
    .RESET      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_o      (add_o),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_ovf    (out_ovf),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  // Real-valued Q1.7 add in integer range, then wrap or clamp.
  function automatic logic [8:0] ref_add(input logic [7:0] a, input logic [7:0] b);
    int         s;
    bit         ov;
    logic [7:0] r;
    s  = int'($signed(a)) + int'($signed(b));
    ov = (s > 127) || (s < -128);
    r  = s[7:0];
`ifdef ADDER_DRV_SAT_EN
    if (ov) r = (s > 0) ? 8'h7F : 8'h80;
`endif
    return {ov, r};
  endfunction

  task automatic offer(input logic [7:0] a, input logic [7:0] b, output bit ok);
    ok = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) begin
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_a = 8'($urandom);
    in_b = 8'($urandom);
    if (ok) exp_q.push_back(ref_add(a, b));
  endtask

  task automatic collect(output logic [7:0] s, output logic o, output bit ok);
    ok = 1'b0;
    s = 8'h00;
    o = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) begin
        s = out_sum;
        o = out_ovf;
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (add_a !== 8'h00) begin errors++; $display("FAIL reset_add_a got=%h exp=00", add_a); end
    checks++; if (add_b !== 8'h00) begin errors++; $display("FAIL reset_add_b got=%h exp=00", add_b); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_sum !== 8'h00) begin errors++; $display("FAIL reset_out_sum got=%h exp=00", out_sum); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf got=%b exp=0", out_ovf); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_a = 8'h20;
    in_b = 8'h20;
    @(negedge clk);  // accepted at the edge just passed
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_c1 got=%b exp=0", in_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", busy); end
    checks++; if (add_a !== 8'h20 || add_b !== 8'h20) begin errors++; $display("FAIL basic_operands got=%h/%h exp=20/20", add_a, add_b); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_c2 got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
    checks++; if (out_sum !== 8'h40 || out_ovf !== 1'b0) begin errors++; $display("FAIL basic_result got=%h/%b exp=40/0", out_sum, out_ovf); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_back got=%b exp=1", in_ready); end
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_popped got=%b exp=0", out_valid); end
  endtask

  task automatic test_order();
    bit ok;
    logic [7:0] s;
    logic o;
    logic [8:0] e;
    offer(8'hE0, 8'hE0, ok);
    offer(8'hE0, 8'h20, ok);
    for (int i = 0; i < 2; i++) begin
      collect(s, o, ok);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
      checks++; if (!ok || {o, s} !== e) begin errors++; $display("FAIL order_%0d got=%b/%h exp=%b/%h", i, o, s, e[8], e[7:0]); end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    logic [7:0] s;
    logic o;
    logic [8:0] e;
    logic [7:0] ops [2];
    ops[0] = 8'h60;
    ops[1] = 8'hA0;
    for (int i = 0; i < 2; i++) begin
      offer(ops[i], ops[i], ok);
      collect(s, o, ok);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h000;
      checks++; if (!ok || {o, s} !== e) begin errors++; $display("FAIL ovf_%0d got=%b/%h exp=%b/%h", i, o, s, e[8], e[7:0]); end
      checks++; if (o !== 1'b1) begin errors++; $display("FAIL ovf_flag_%0d got=%b exp=1", i, o); end
    end
  endtask

  task automatic test_full();
    bit ok;
    logic [7:0] s;
    logic o;
    logic [8:0] e;
    logic [7:0] a5;
    logic [7:0] b5;
    for (int i = 0; i < 4; i++) begin
      offer(8'($urandom), 8'($urandom), ok);
      checks++; if (!ok) begin errors++; $display("FAIL full_offer_%0d got=timeout exp=accept", i); end
    end
    a5 = 8'($urandom);
    b5 = 8'($urandom);
    in_valid = 1'b1;
    in_a = a5;
    in_b = b5;
    repeat (6) @(negedge clk);
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count got=%0d exp=4", fifo_count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
    collect(s, o, ok);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
    checks++; if (!ok || {o, s} !== e) begin errors++; $display("FAIL full_drain_0 got=%b/%h exp=%b/%h", o, s, e[8], e[7:0]); end
    checks++; if (fifo_count !== 3'd3 || in_ready !== 1'b1) begin errors++; $display("FAIL full_after_pop got=cnt%0d rdy%b exp=cnt3 rdy1", fifo_count, in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    exp_q.push_back(ref_add(a5, b5));
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_fifth_accept got=%b exp=1", busy); end
    for (int i = 1; i < 5; i++) begin
      collect(s, o, ok);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
      checks++; if (!ok || {o, s} !== e) begin errors++; $display("FAIL full_drain_%0d got=%b/%h exp=%b/%h", i, o, s, e[8], e[7:0]); end
    end
  endtask

  task automatic test_push_pop();
    bit ok;
    logic [7:0] s;
    logic o;
    logic [8:0] e;
    offer(8'h10, 8'h05, ok);
    repeat (3) @(negedge clk);
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL pp_setup got=%0d exp=1", fifo_count); end
    offer(8'($urandom), 8'($urandom), ok);
    @(negedge clk);  // driver now in CAPTURE
    checks++; if (fifo_count !== 3'd1 || busy !== 1'b1) begin errors++; $display("FAIL pp_pre got=cnt%0d busy%b exp=cnt1 busy1", fifo_count, busy); end
    e = exp_q[0];
    checks++; if ({out_ovf, out_sum} !== e) begin errors++; $display("FAIL pp_old_head got=%b/%h exp=%b/%h", out_ovf, out_sum, e[8], e[7:0]); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    void'(exp_q.pop_front());
    e = exp_q[0];
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL pp_count got=%0d exp=1", fifo_count); end
    checks++; if ({out_ovf, out_sum} !== e) begin errors++; $display("FAIL pp_new_head got=%b/%h exp=%b/%h", out_ovf, out_sum, e[8], e[7:0]); end
    collect(s, o, ok);
    void'(exp_q.pop_front());
    checks++; if (!ok || {o, s} !== e) begin errors++; $display("FAIL pp_drain got=%b/%h exp=%b/%h", o, s, e[8], e[7:0]); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    offer(8'h11, 8'h22, ok);
    offer(8'h33, 8'h44, ok);
    repeat (3) @(negedge clk);
    offer(8'h55, 8'h01, ok);
    checks++; if (busy !== 1'b1 || fifo_count !== 3'd2) begin errors++; $display("FAIL rm_pre got=busy%b cnt%0d exp=busy1 cnt2", busy, fifo_count); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_out_valid got=%b exp=0", out_valid); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rm_count got=%0d exp=0", fifo_count); end
    checks++; if (add_a !== 8'h00 || add_b !== 8'h00) begin errors++; $display("FAIL rm_operands got=%h/%h exp=00/00", add_a, add_b); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got=%b exp=0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    repeat (6) @(negedge clk);
    checks++; if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL rm_stale got=v%b cnt%0d exp=v0 cnt0", out_valid, fifo_count); end
  endtask

  task automatic test_random();
    bit ok;
    logic [7:0] s;
    logic o;
    logic [8:0] e;
    logic [7:0] edges [4];
    logic [7:0] a;
    logic [7:0] b;
    edges[0] = 8'h7F; edges[1] = 8'h80; edges[2] = 8'h00; edges[3] = 8'hFF;
    for (int i = 0; i < 30; i++) begin
      a = ($urandom_range(3) == 0) ? edges[$urandom_range(3)] : 8'($urandom);
      b = ($urandom_range(3) == 0) ? edges[$urandom_range(3)] : 8'($urandom);
      offer(a, b, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand_offer_%0d got=timeout exp=accept", i); end
      if (exp_q.size() >= 4 || $urandom_range(1) == 1) begin
        collect(s, o, ok);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
        checks++; if (!ok || {o, s} !== e) begin errors++; $display("FAIL rand_%0d got=%b/%h exp=%b/%h", i, o, s, e[8], e[7:0]); end
      end
    end
    while (exp_q.size() > 0) begin
      collect(s, o, ok);
      e = exp_q.pop_front();
      checks++; if (!ok || {o, s} !== e) begin errors++; $display("FAIL rand_drain got=%b/%h exp=%b/%h", o, s, e[8], e[7:0]); end
      if (!ok) exp_q.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_order();
    test_overflow();
    test_full();
    test_push_pop();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
